// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB pipeline register with load extraction, write-back select and retire counter
// Load data is big-endian: byte lane 0 is the most significant byte of In_ReadData.

module mem_wb_register #(
  parameter int LINK_OFFSET = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic                   In_Valid,
  input  logic [31:0]            In_ReadData,
  input  logic [31:0]            In_ALUResult,
  input  logic [31:0]            In_PC,
  input  logic [4:0]             In_WriteReg,
  input  logic                   In_RegWrite,
  input  logic                   In_MemToReg,
  input  logic                   In_Link,
  input  logic [2:0]             In_LoadType,
  output logic                   WB_Valid,
  output logic                   WB_RegWrite,
  output logic [4:0]             WB_WriteReg,
  output logic [31:0]            WB_WriteData,
  output logic                   WB_MisalignExc,
  output logic [COUNT_WIDTH-1:0] RetireCount
);

  localparam logic [2:0] LoadLb  = 3'b001;
  localparam logic [2:0] LoadLbu = 3'b010;
  localparam logic [2:0] LoadLh  = 3'b011;
  localparam logic [2:0] LoadLhu = 3'b100;

  localparam logic [31:0] LinkOffsetW = 32'(LINK_OFFSET);

  logic [1:0]  addr;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;
  logic        isHalf;
  logic        isWord;
  logic        misaligned;
  logic [31:0] linkAddr;
  logic [31:0] writeDataNext;
  logic        regWriteNext;
  logic        retire;

  assign addr = In_ALUResult[1:0];

  always_comb begin
    byteSel = In_ReadData[31:24];
    case (addr)
      2'd0: byteSel = In_ReadData[31:24];
      2'd1: byteSel = In_ReadData[23:16];
      2'd2: byteSel = In_ReadData[15:8];
      2'd3: byteSel = In_ReadData[7:0];
      default: byteSel = In_ReadData[31:24];
    endcase
  end

  // Misaligned halfwords still pick a lane by addr[1]; the value is discarded downstream.
  assign halfSel = addr[1] ? In_ReadData[15:0] : In_ReadData[31:16];

  always_comb begin
    loadData = In_ReadData;
    isHalf   = 1'b0;
    isWord   = 1'b0;
    case (In_LoadType)
      LoadLb:  loadData = {{24{byteSel[7]}}, byteSel};
      LoadLbu: loadData = {24'd0, byteSel};
      LoadLh: begin
        loadData = {{16{halfSel[15]}}, halfSel};
        isHalf   = 1'b1;
      end
      LoadLhu: begin
        loadData = {16'd0, halfSel};
        isHalf   = 1'b1;
      end
      default: begin
        loadData = In_ReadData;
        isWord   = 1'b1;
      end
    endcase
  end

  assign misaligned = In_Valid & In_MemToReg &
                      ((isHalf & addr[0]) | (isWord & (addr != 2'd0)));

  assign linkAddr = In_PC + LinkOffsetW;

  always_comb begin
    writeDataNext = In_ALUResult;
    if (In_Link) begin
      writeDataNext = linkAddr;
    end else if (In_MemToReg) begin
      writeDataNext = loadData;
    end
  end

  assign regWriteNext = In_Valid & In_RegWrite & (In_WriteReg != 5'd0) & ~misaligned;
  assign retire       = In_Valid & ~misaligned;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      WB_Valid       <= 1'b0;
      WB_RegWrite    <= 1'b0;
      WB_WriteReg    <= 5'd0;
      WB_WriteData   <= 32'd0;
      WB_MisalignExc <= 1'b0;
      RetireCount    <= '0;
    end else if (Flush) begin
      WB_Valid       <= 1'b0;
      WB_RegWrite    <= 1'b0;
      WB_WriteReg    <= 5'd0;
      WB_WriteData   <= 32'd0;
      WB_MisalignExc <= 1'b0;
    end else if (!Stall) begin
      WB_Valid       <= In_Valid;
      WB_RegWrite    <= regWriteNext;
      WB_WriteReg    <= In_WriteReg;
      WB_WriteData   <= writeDataNext;
      WB_MisalignExc <= misaligned;
      if (retire) begin
        RetireCount <= RetireCount + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_register.sv
// tb/tb_mem_wb_register.sv - directed scoreboard bench for mem_wb_register
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.

module tb_mem_wb_register;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        In_Valid;
  logic [31:0] In_ReadData;
  logic [31:0] In_ALUResult;
  logic [31:0] In_PC;
  logic [4:0]  In_WriteReg;
  logic        In_RegWrite;
  logic        In_MemToReg;
  logic        In_Link;
  logic [2:0]  In_LoadType;

  logic        WB_Valid;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        WB_MisalignExc;
  logic [31:0] RetireCount;

  logic        sValid;
  logic        sRegWrite;
  logic [4:0]  sWriteReg;
  logic [31:0] sWriteData;
  logic        sMisalignExc;
  logic [3:0]  sRetireCount;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        misalign;
    logic [31:0] count;
  } exp_t;

  exp_t sbq[$];
  exp_t lastExp;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] expCount = 32'd0;

  always #5 Clock = ~Clock;

  mem_wb_register #(.LINK_OFFSET(8), .COUNT_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .In_Valid(In_Valid), .In_ReadData(In_ReadData), .In_ALUResult(In_ALUResult),
    .In_PC(In_PC), .In_WriteReg(In_WriteReg), .In_RegWrite(In_RegWrite),
    .In_MemToReg(In_MemToReg), .In_Link(In_Link), .In_LoadType(In_LoadType),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_WriteData(WB_WriteData), .WB_MisalignExc(WB_MisalignExc),
    .RetireCount(RetireCount)
  );

  mem_wb_register #(.LINK_OFFSET(8), .COUNT_WIDTH(4)) dutSmall (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .In_Valid(In_Valid), .In_ReadData(In_ReadData), .In_ALUResult(In_ALUResult),
    .In_PC(In_PC), .In_WriteReg(In_WriteReg), .In_RegWrite(In_RegWrite),
    .In_MemToReg(In_MemToReg), .In_Link(In_Link), .In_LoadType(In_LoadType),
    .WB_Valid(sValid), .WB_RegWrite(sRegWrite), .WB_WriteReg(sWriteReg),
    .WB_WriteData(sWriteData), .WB_MisalignExc(sMisalignExc),
    .RetireCount(sRetireCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [4:0] wr, input logic rw,
                       input logic m2r, input logic lnk, input logic [2:0] lt);
    In_Valid     = v;
    In_ReadData  = rd;
    In_ALUResult = alu;
    In_PC        = pc;
    In_WriteReg  = wr;
    In_RegWrite  = rw;
    In_MemToReg  = m2r;
    In_Link      = lnk;
    In_LoadType  = lt;
  endtask

  task automatic driveRandom();
    drive(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1, 1'($urandom),
          1'($urandom), 3'($urandom));
  endtask

  task automatic push(input logic v, input logic rw, input logic [4:0] wr,
                      input logic [31:0] wd, input logic mis);
    exp_t e;
    e.valid     = v;
    e.regWrite  = rw;
    e.writeReg  = wr;
    e.writeData = wd;
    e.misalign  = mis;
    e.count     = expCount;
    lastExp     = e;
    sbq.push_back(e);
  endtask

  task automatic pushHold();
    sbq.push_back(lastExp);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".valid"},     {31'd0, WB_Valid},       {31'd0, e.valid});
      chk({tag, ".regwrite"},  {31'd0, WB_RegWrite},    {31'd0, e.regWrite});
      chk({tag, ".writereg"},  {27'd0, WB_WriteReg},    {27'd0, e.writeReg});
      chk({tag, ".writedata"}, WB_WriteData,            e.writeData);
      chk({tag, ".misalign"},  {31'd0, WB_MisalignExc}, {31'd0, e.misalign});
      chk({tag, ".count"},     RetireCount,             e.count);
      chk({tag, ".count4"},    {28'd0, sRetireCount},   {28'd0, e.count[3:0]});
    end
  endtask

  initial begin
    Reset = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;

    // Reset held for two edges with random inputs
    driveRandom();
    push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step("reset0");
    driveRandom();
    Stall = 1'b1;
    Flush = 1'b1;
    push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step("reset1");

    Reset = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0011, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    expCount = 1;
    push(1'b1, 1'b1, 5'd3, 32'h0000_0011, 1'b0);
    step("first_alu");

    // Load extraction, one capture per cycle
    drive(1'b1, 32'h80FF_7F01, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b001);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0); step("lb_a0");
    drive(1'b1, 32'h80FF_7F01, 32'h101, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'h0000_00FF, 1'b0); step("lbu_a1");
    drive(1'b1, 32'h80FF_7F01, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b001);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'h0000_0001, 1'b0); step("lb_a3");
    drive(1'b1, 32'h80FF_7F01, 32'h102, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b011);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'h0000_7F01, 1'b0); step("lh_a2");
    drive(1'b1, 32'h80FF_7F01, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b011);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'hFFFF_80FF, 1'b0); step("lh_a0");
    drive(1'b1, 32'h80FF_7F01, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b100);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'h0000_80FF, 1'b0); step("lhu_a0");
    drive(1'b1, 32'h80FF_7F01, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    expCount++; push(1'b1, 1'b1, 5'd5, 32'h80FF_7F01, 1'b0); step("lw_a0");
    drive(1'b1, 32'h1357_9BDF, 32'h200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b111);
    expCount++; push(1'b1, 1'b1, 5'd6, 32'h1357_9BDF, 1'b0); step("ltype_other");

    // Misaligned loads do not write or retire
    drive(1'b1, 32'h80FF_7F01, 32'h1002, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000);
    push(1'b1, 1'b0, 5'd5, 32'h80FF_7F01, 1'b1); step("lw_misalign");
    drive(1'b1, 32'h80FF_7F01, 32'h1001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b011);
    push(1'b1, 1'b0, 5'd9, 32'hFFFF_80FF, 1'b1); step("lh_misalign");
    drive(1'b1, 32'h80FF_7F01, 32'h1003, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001);
    expCount++; push(1'b1, 1'b1, 5'd9, 32'h0000_0001, 1'b0); step("lb_odd_ok");

    drive(1'b1, 32'h0, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    expCount++; push(1'b1, 1'b0, 5'd0, 32'h55, 1'b0); step("zero_reg");

    // Link select overrides MemToReg, including 32-bit wrap
    drive(1'b1, 32'hAAAA_AAAA, 32'h0, 32'h0040_0010, 5'd31, 1'b1, 1'b1, 1'b1, 3'b000);
    expCount++; push(1'b1, 1'b1, 5'd31, 32'h0040_0018, 1'b0); step("link");
    drive(1'b1, 32'hAAAA_AAAA, 32'h0, 32'hFFFF_FFFC, 5'd31, 1'b1, 1'b1, 1'b1, 3'b000);
    expCount++; push(1'b1, 1'b1, 5'd31, 32'h0000_0004, 1'b0); step("link_wrap");

    // Stall holds, Flush wins over Stall
    drive(1'b1, 32'h0, 32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000);
    expCount++; push(1'b1, 1'b1, 5'd7, 32'h1234, 1'b0); step("pre_stall");
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      driveRandom();
      pushHold();
      step("stall_hold");
    end
    Flush = 1'b1;
    driveRandom();
    push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0); step("stall_flush");
    Stall = 1'b0;
    drive(1'b1, 32'h0, 32'h77, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
    push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0); step("flush_only");
    Flush = 1'b0;
    drive(1'b1, 32'h0, 32'h99, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    expCount++; push(1'b1, 1'b1, 5'd2, 32'h99, 1'b0); step("post_flush");

    // Reset during stall
    Stall = 1'b1;
    driveRandom();
    pushHold(); step("stall_before_reset");
    Reset = 1'b0;
    driveRandom();
    expCount = 0;
    push(1'b0, 1'b0, 5'd0, 32'd0, 1'b0); step("reset_in_stall");
    Reset = 1'b1;
    Stall = 1'b0;

    // 17 captures: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h0, 32'(i * 3), 32'h0, 5'(1 + i), 1'b1, 1'b0, 1'b0, 3'b000);
      expCount++;
      push(1'b1, 1'b1, 5'(1 + i), 32'(i * 3), 1'b0);
      step("wrap_run");
    end
    chk("wrap_final4", {28'd0, sRetireCount}, 32'd1);
    chk("wrap_final32", RetireCount, 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_register.md
Name: mem_wb_register

Overview:
- Pipeline register between the MEM stage (data memory read port) and the register-file write-back port.
- Captures the MEM-stage results, then extracts and sign/zero-extends load data (LW/LH/LHU/LB/LBU).
- Selects the write-back value (load data, ALU result or link address) and registers it with a 1-cycle latency.
- Supports stall, flush, misaligned-load detection and a retired-instruction counter.

Parameters:
- LINK_OFFSET, 8, constant added to In_PC for link (JAL/JALR) write-back.
- COUNT_WIDTH, 32, width of RetireCount; the counter wraps modulo 2^COUNT_WIDTH.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Stall  input  1  hold all registered state.
- Flush  input  1  replace the captured instruction with a bubble.
- In_Valid  input  1  MEM stage holds a real instruction.
- In_ReadData  input  32  word from data memory.
- In_ALUResult  input  32  ALU result / effective address.
- In_PC  input  32  PC of the instruction.
- In_WriteReg  input  5  destination register.
- In_RegWrite  input  1  instruction writes the register file.
- In_MemToReg  input  1  select load data.
- In_Link  input  1  select In_PC+LINK_OFFSET (overrides In_MemToReg).
- In_LoadType  input  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes are treated as LW.
- WB_Valid  output  1  registered valid.
- WB_RegWrite  output  1  register-file write enable.
- WB_WriteReg  output  5  register-file write address.
- WB_WriteData  output  32  register-file write data.
- WB_MisalignExc  output  1  misaligned load reached write-back.
- RetireCount  output  COUNT_WIDTH  instructions retired.

Behaviour:
- Reset and priority:
  - All outputs are registered. Reset (Reset==0 at a rising edge) clears every output to 0.
  - Reset has priority over Flush and Stall, and takes effect mid-stall as well.
  - At each rising edge with Reset==1, priority is Flush > Stall > capture.
- Flush: WB_Valid, WB_RegWrite and WB_MisalignExc go to 0. WB_WriteReg and WB_WriteData go to 0. RetireCount is unchanged.
- Stall: every output holds its value, RetireCount included.
- Capture: outputs take the values computed from the In_* signals in the same cycle. Latency is 1 cycle.
- Byte lane addressing: big-endian; addr = In_ALUResult[1:0].
  - Byte lane k is In_ReadData[31-8k -: 8].
  - Halfword at addr 0 is [31:16]; at addr 2 it is [15:0].
- Load extraction:
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend; LW passes In_ReadData unchanged.
- Misalignment:
  - Defined as: LH/LHU with addr[0]==1, or LW with addr!=0, when In_MemToReg==1 and In_Valid==1.
  - On misalignment, WB_MisalignExc=1 and WB_RegWrite=0.
  - WB_WriteData still holds the extracted value; it is not used.
- Write-data select:
  - In_Link=1: WB_WriteData = In_PC + LINK_OFFSET, truncated to 32 bits.
  - Otherwise In_MemToReg=1: WB_WriteData = the extracted load value.
  - Otherwise: WB_WriteData = In_ALUResult.
- WB_RegWrite = In_Valid & In_RegWrite & (In_WriteReg != 0) & ~misaligned. Writes to $zero are never issued.
- Bubbles: when In_Valid==0, WB_RegWrite=0 and WB_MisalignExc=0. WB_WriteReg and WB_WriteData are still captured; they are don't-care.
- RetireCount:
  - Increments by 1 on every capture edge with In_Valid==1 and no misalignment.
  - Wraps from all-ones to 0.
  - Not incremented on Flush, Stall or Reset edges; cleared by Reset.
- Simultaneous Flush and Stall: Flush wins and a bubble is inserted.
- Consecutive captures need no idle cycle: full throughput, one instruction per cycle.

Test Plan:
- Reset: hold Reset=0 for 2 edges with random inputs -> all outputs 0 and RetireCount=0; release -> first valid capture gives RetireCount=1.
- Load extraction: In_ReadData=0x80FF7F01, MemToReg=1, RegWrite=1, WriteReg=5, valid, one capture per cycle:
  - LB addr0 -> 0xFFFFFF80.
  - LBU addr1 -> 0x000000FF.
  - LB addr3 -> 0x00000001.
  - LH addr2 -> 0x00007F01.
  - LH addr0 -> 0xFFFF80FF.
  - LHU addr0 -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - Expect WB_RegWrite=1 each cycle and RetireCount to advance by 7.
- Misalign and $zero:
  - LW addr 0x1002 -> WB_MisalignExc=1, WB_RegWrite=0, RetireCount unchanged.
  - ALU op with WriteReg=0 -> WB_RegWrite=0, RetireCount+1.
- Link select: In_Link=1, In_PC=0x00400010, MemToReg=1 -> WB_WriteData=0x00400018.
  - Wrap case: In_PC=0xFFFFFFFC -> WB_WriteData=0x00000004.
- Stall/flush:
  - Capture ALU result 0x1234, then Stall=1 for 3 cycles with changing inputs -> outputs hold 0x1234.
  - Stall=1 and Flush=1 together -> WB_Valid=0, WB_RegWrite=0, WB_WriteData=0.
  - Reset asserted during a stall -> outputs cleared on that edge.
- Counter wrap: COUNT_WIDTH=4, 17 valid captures -> RetireCount=1.
